// File: rtl/seqmult_dispatch.sv
// seqmult_dispatch: FIFO-buffered job feeder for a sequential multiplier.
// Optional watchdog on WAIT_DONE: define SEQMULT_DISPATCH_TIMEOUT_EN.
module seqmult_dispatch #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 33554432
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic                     mul_ready,
    input  logic [2*WIDTH-1:0]       mul_p,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       out_p,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [FW-1:0] FILL_ONE = 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_HOLD   = 3'd2,
        S_WAIT   = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      mem_a_q [DEPTH];
    logic [WIDTH-1:0]      mem_b_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic [WIDTH-1:0]      mul_a_q, mul_a_d;
    logic [WIDTH-1:0]      mul_b_q, mul_b_d;
    logic                  out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]    out_p_q, out_p_d;
    logic                  push;
    logic                  pop;

`ifdef SEQMULT_DISPATCH_TIMEOUT_EN
    localparam logic [25:0] TO_LIM = 26'(TIMEOUT);
    logic [25:0]           cnt_q, cnt_d;
    logic                  err_q, err_d;
`endif

    // Handshake decode: no pass-through when full, pop only on dispatch.
    always_comb begin
        in_ready = (fill_q != FILL_MAX);
        push     = in_valid && in_ready;
        pop      = (state_q == S_IDLE) && (fill_q != '0)
                   && mul_ready && !out_valid_q;
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        unique case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_ONE;
            2'b01:   fill_d = fill_q - FILL_ONE;
            default: fill_d = fill_q;
        endcase
    end

    // Job sequencing: dispatch, two-cycle start, wait, result handshake.
    always_comb begin
        state_d     = state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
`ifdef SEQMULT_DISPATCH_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_START;
                    mul_a_d = mem_a_q[rd_ptr_q];
                    mul_b_d = mem_b_q[rd_ptr_q];
                end
            end
            S_START: state_d = S_HOLD;
            S_HOLD: begin
                state_d = S_WAIT;
`ifdef SEQMULT_DISPATCH_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (mul_ready) begin
                    out_p_d     = mul_p;
                    out_valid_d = 1'b1;
                    state_d     = S_RESULT;
                end
`ifdef SEQMULT_DISPATCH_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 26'd1;
                    if (cnt_d == TO_LIM) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
`endif
            end
            S_RESULT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers, cleared by the async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= in_a;
            mem_b_q[wr_ptr_q] <= in_b;
        end
    end

`ifdef SEQMULT_DISPATCH_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign mul_start = (state_q == S_START) || (state_q == S_HOLD);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign busy      = (state_q != S_IDLE);
    assign fill      = fill_q;

endmodule

// File: tb/tb_seqmult_dispatch.sv
// tb_seqmult_dispatch: scoreboard bench with a behavioural multiplier model.
// Expected products come from operand pairs at push time.
module tb_seqmult_dispatch;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int TO = 50;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid, in_ready;
    logic [W-1:0]     in_a, in_b;
    logic             mul_start;
    logic [W-1:0]     mul_a, mul_b;
    logic             mul_ready;
    logic [2*W-1:0]   mul_p;
    logic             out_valid, out_ready;
    logic [2*W-1:0]   out_p;
    logic             busy;
    logic [2:0]       fill;
    logic             err;

    seqmult_dispatch #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ready(mul_ready), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .busy(busy), .fill(fill), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] exp_q[$];
    int  peak;
    logic [2*W-1:0] last_out;
    bit  rand_or = 0;
    bit  hang = 0;
    bit  lat_rand = 0;
    int  lat_fix = 20;
    bit  bp_done;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic tmo(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // Multiplier controller model: Idle -> Init -> Busy(latency) -> Idle.
    int ms, mcnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms <= 0; mcnt <= 0; mul_ready <= 1'b1; mul_p <= '0;
        end else begin
            case (ms)
                0: if (mul_start) begin ms <= 1; mul_ready <= 1'b0; end
                1: if (mul_start) begin
                        ms <= 2;
                        mcnt <= lat_rand ? int'($urandom_range(1, 20)) : lat_fix;
                    end else begin
                        ms <= 0; mul_ready <= 1'b1;
                    end
                default: if (!hang) begin
                    if (mcnt <= 1) begin
                        ms <= 0; mul_ready <= 1'b1;
                        mul_p <= 16'(mul_a) * 16'(mul_b);
                    end else mcnt <= mcnt - 1;
                end
            endcase
        end
    end

    // Monitor: records pushes, checks results and invariants at negedge.
    int srun = 0;
    bit prev_hold = 0, prev_err = 0;
    logic [2*W-1:0] prev_p;
    always @(negedge clk) begin
        logic [2*W-1:0] pr, e;
        if (!rst) begin
            exp_q.delete();
            srun = 0;
            prev_hold = 0;
            prev_err = 0;
        end else begin
            chk("in_ready_vs_fill", in_ready, fill != 3'(D));
            if (32'(fill) > peak) peak = fill;
            if (in_valid && in_ready) begin
                pr = 16'(in_a) * 16'(in_b);
                exp_q.push_back(pr);
            end
            if (mul_start) srun++;
            else if (srun != 0) begin
                chk("start_len", srun, 2);
                srun = 0;
            end
            if (out_valid) chk("no_start_in_result", mul_start, 0);
            if (prev_hold && out_valid) chk("out_p_hold", out_p, prev_p);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got %0d want none", out_p);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_p", out_p, e);
                    last_out = out_p;
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_p = out_p;
            if (err && !prev_err && exp_q.size() > 0) void'(exp_q.pop_front());
            prev_err = err;
        end
    end

    // Random consumer backpressure during the random phase.
    initial forever begin
        @(posedge clk); #1;
        if (rand_or) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        in_a = a; in_b = b; in_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!in_ready && n < 500);
        if (n >= 500) tmo("push");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < budget);
        if (!out_valid) tmo("wait_valid");
        @(posedge clk); #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(exp_q.size() == 0 && !busy && !out_valid && fill == 0)
               && n < budget);
        if (n >= budget) tmo("drain");
        @(posedge clk); #1;
    endtask

    initial begin
        int stable_bad;
        int n;
        in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
        rst = 0;
        cycles(3);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fill", fill, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_mul_ab", {mul_a, mul_b}, 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst = 1;
        cycles(2);

        // single job, held result
        lat_fix = 20;
        push(3, 5);
        stable_bad = 0;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (busy && (mul_a != 3 || mul_b != 5)) stable_bad++;
        end while (!out_valid && n < 100);
        if (!out_valid) tmo("single_valid");
        chk("single_ab_stable", stable_bad, 0);
        @(posedge clk); #1;
        cycles(4);
        chk("single_held_valid", out_valid, 1);
        chk("single_held_p", out_p, 15);
        chk("single_mul_a_kept", mul_a, 3);
        out_ready = 1;
        cycles(1);
        out_ready = 0;
        cycles(1);
        chk("single_cleared", out_valid, 0);
        chk("single_last", last_out, 15);

        // ordering, back-to-back
        lat_fix = 5;
        out_ready = 1;
        peak = 0;
        push(2, 7); push(9, 9); push(255, 255); push(0, 4);
        drain(500);
        chk("order_peak_ge3", peak >= 3, 1);
        chk("order_last", last_out, 0);

        // backpressure and full with simultaneous pop
        lat_fix = 3;
        out_ready = 0;
        push(10, 11);
        wait_valid(100);
        bp_done = 0;
        fork
            begin
                push(1, 2); push(3, 4); push(5, 6); push(7, 8); push(9, 10);
                bp_done = 1;
            end
        join_none
        cycles(12);
        chk("bp_fill_full", fill, 4);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_fifth_waiting", in_valid, 1);
        chk("bp_valid_held", out_valid, 1);
        out_ready = 1;
        cycles(1);
        out_ready = 0;
        @(negedge clk);
        chk("full_pop_fill", fill, 4);
        chk("full_pop_in_ready", in_ready, 0);
        chk("full_pop_idle", busy, 0);
        @(negedge clk);
        chk("full_after_pop_fill", fill, 3);
        chk("full_after_pop_start", mul_start, 1);
        @(negedge clk);
        chk("full_refill", fill, 4);
        @(posedge clk); #1;
        out_ready = 1;
        drain(1000);
        chk("bp_push_done", bp_done, 1);

        // reset mid-WAIT_DONE
        lat_fix = 30;
        out_ready = 0;
        push(6, 7);
        cycles(6);
        push(1, 2);
        rst = 0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_start", mul_start, 0);
        chk("mrst_fill", fill, 0);
        chk("mrst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1;
        cycles(2);
        lat_fix = 4;
        out_ready = 1;
        push(4, 4);
        drain(300);
        chk("mrst_next_p", last_out, 16);

        // randomized jobs with random consumer stalls
        lat_rand = 1;
        rand_or = 1;
        for (int i = 0; i < 40; i++) begin
            push(W'($urandom), W'($urandom));
            cycles($urandom_range(0, 3));
        end
        rand_or = 0;
        #1;
        out_ready = 1;
        drain(3000);
        lat_rand = 0;

`ifdef SEQMULT_DISPATCH_TIMEOUT_EN
        // watchdog: controller never returns ready
        hang = 1;
        lat_fix = 3;
        push(1, 1);
        n = 0;
        begin
            int wc = 0;
            do begin
                @(negedge clk); n++;
                if (busy && !mul_start && !out_valid) wc++;
            end while (!err && n < 300);
            if (!err) tmo("timeout_err");
            chk("timeout_cycles", wc, TO);
            chk("timeout_no_valid", out_valid, 0);
            chk("timeout_idle", busy, 0);
        end
        @(posedge clk); #1;
        hang = 0;
        push(2, 3);
        drain(300);
        chk("timeout_next_p", last_out, 6);
        chk("timeout_err_sticky", err, 1);
`else
        chk("err_tied_low", err, 0);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/seqmult_dispatch.md
Name: seqmult_dispatch

Overview:
- Upstream job feeder for the sequential multiplier controller/datapath.
- Buffers operand pairs from a valid/ready producer in a small FIFO and presents one pair at a time on stable operand buses.
- Generates the two-cycle start sequence the multiplier controller needs, then waits for its ready to return.
- Captures the product into an output register with valid/ready handshake toward the consumer.

Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- TIMEOUT, 33554432, watchdog limit in cycles for WAIT_DONE; only used when the optional feature is compiled in.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer offers an operand pair.
- in_ready  out  1  FIFO can accept; equals !full.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- mul_start  out  1  start to multiplier controller.
- mul_a  out  WIDTH  operand A to datapath; held stable per job.
- mul_b  out  WIDTH  operand B to datapath; held stable per job.
- mul_ready  in  1  ready from multiplier controller; high only in its Idle state.
- mul_p  in  2*WIDTH  product from datapath.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_p  out  2*WIDTH  registered product.
- busy  out  1  high in any state other than IDLE.
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy.
- err  out  1  sticky watchdog error; constant 0 without the optional feature.

Behaviour:
- Reset (rst low, async): state=IDLE, FIFO empty (fill=0), mul_start=0, mul_a=mul_b=0, out_valid=0, out_p=0, err=0.
- in_ready=1 after reset.
- FIFO push: occurs when in_valid && in_ready.
- FIFO pop: occurs only on the IDLE->START transition.
  - Push and pop in the same cycle: fill unchanged.
  - When full, in_ready=0 even if a pop happens that cycle (no pass-through).
  - Pointers wrap modulo DEPTH.
- FSM states and transitions:
  - IDLE -> START when fill!=0 && mul_ready && !out_valid. FIFO head is latched into mul_a/mul_b on this edge.
  - START: mul_start=1 (controller in its Idle state). Unconditionally -> HOLD.
  - HOLD: mul_start=1 (controller in its Init state, which still requires start high). Unconditionally -> WAIT_DONE.
  - WAIT_DONE: mul_start=0. Stay while mul_ready=0. When mul_ready=1, capture mul_p into out_p, set out_valid=1, -> RESULT.
  - RESULT: hold out_valid and out_p. When out_ready=1, clear out_valid -> IDLE.
- Cycle timing:
  - mul_start is high for exactly 2 consecutive cycles per job.
  - out_valid rises on the first edge on which mul_ready=1 is sampled in WAIT_DONE.
  - Minimum job-to-job spacing is 5 cycles plus multiplier latency.
- mul_a/mul_b are changed only on the IDLE->START edge. They stay stable through the multiplier's load and shift phases and keep their last values when idle.
- The FIFO keeps accepting pushes in all states, including RESULT with out_ready low.
- out_p and out_valid are registered; no combinational path from mul_p to out_p.
- Reset mid-operation: the in-flight job and all FIFO contents are discarded. The multiplier controller is reset by the same top-level reset (inverted for its active-high input).
- Unused state encodings -> IDLE.

Optional Feature:
- Macro SEQMULT_DISPATCH_TIMEOUT_EN.
- Defined:
  - A 26-bit cycle counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - When it reaches TIMEOUT, set err=1 (sticky until reset), drop the job without asserting out_valid, and go to IDLE.
  - The dispatcher does not re-dispatch while mul_ready=0, because the IDLE guard requires mul_ready.
- Not defined: no counter logic; err tied to 0; WAIT_DONE waits indefinitely.

Test Plan:
- Single job: push a=3, b=5; multiplier model returns ready 20 cycles after start. Expect mul_start high exactly 2 cycles, mul_a=3/mul_b=5 stable throughout, then out_valid=1, out_p=15, held until out_ready.
- Ordering: push (2,7), (9,9), (255,255), (0,4) back-to-back with out_ready=1. Expect outputs 14, 81, 65025, 0 in order, and fill peaking at 3 or 4.
- Backpressure: out_ready=0, push 5 pairs with DEPTH=4. Expect in_ready=0 once fill=4, fifth pair accepted only after the first result is drained and the FIFO pops. Expect no second mul_start while out_valid=1.
- Full plus simultaneous push: with fill=4 and a pop occurring, hold in_valid=1. Expect in_ready=0 that cycle, fill=3 next cycle, then the push accepted.
- Reset mid-WAIT_DONE: pull rst low for 1 cycle during a job. Expect immediate out_valid=0, mul_start=0, fill=0, busy=0. The next pushed job (4,4) gives out_p=16.
- With SEQMULT_DISPATCH_TIMEOUT_EN and TIMEOUT=50: hold mul_ready=0 after start. Expect err=1 at cycle 50 of WAIT_DONE, no out_valid, state IDLE, err stays 1 after later successful jobs.
